// File: rtl/mux_operand_loader_pkg.sv
// Shared definitions for the mux operand loader: state encoding,
// default parameter values and the hold counter width.
package mux_operand_loader_pkg;

  // Loader states; encoding 2'd3 is unused and recovers to LOAD_A.
  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_e;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/mux_operand_loader_hold_counter.sv
// 8-bit presentation counter. start/clr zero it synchronously, en
// increments it, and tc flags the last cycle of the hold window.
module mux_operand_loader_hold_counter
  import mux_operand_loader_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: restart wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (start || clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mux_operand_loader.sv
// Captures two consecutive nibbles from a valid/ready stream as operands
// A and B, then presents them for HOLD_CYCLES cycles with an alternating
// select key so the downstream 2:1 mux emits A, B, A, B, ...
module mux_operand_loader
  import mux_operand_loader_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             key,
  output logic             out_valid
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             key_q, key_d;
  logic             out_valid_q, out_valid_d;

  logic xfer;
  logic cnt_start, cnt_clr, cnt_en, cnt_tc;

  // Ready depends on state only, so upstream never sees a path from in_valid.
  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign xfer     = in_valid && in_ready;

  mux_operand_loader_hold_counter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cnt_start),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // Next-state and operand capture; clear overrides any same-edge transfer.
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    key_d     = key_q;
    cnt_start = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    if (clear) begin
      state_d = LOAD_A;
      key_d   = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (xfer) begin
            op_a_d  = in_data;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (xfer) begin
            op_b_d    = in_data;
            state_d   = PRESENT;
            key_d     = 1'b0;
            cnt_start = 1'b1;
          end
        end
        PRESENT: begin
          if (cnt_tc) begin
            state_d = LOAD_A;
            key_d   = 1'b0;
            cnt_clr = 1'b1;
          end else begin
            key_d  = ~key_q;
            cnt_en = 1'b1;
          end
        end
        default: begin
          state_d = LOAD_A;
          key_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // out_valid is registered from the next state so it is glitch-free.
  always_comb begin
    out_valid_d = (state_d == PRESENT);
  end

  // State, operand and presentation registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      key_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      key_q       <= key_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign key       = key_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_operand_loader.sv
// Bench for mux_operand_loader: three builds (HOLD_CYCLES 4, 1, 3) share
// the same input stream; a pair/window reference model checks all of them
// every cycle, and a hand-built table checks the HOLD_CYCLES=4 build.
module tb_mux_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;

  logic [2:0]      rdy, ov, key;
  logic [2:0][3:0] opa, opb;
  logic [3:0]      mux_out4;

  int total = 0;
  int bad   = 0;

  int         hold [3] = '{4, 1, 3};
  int         ph   [3];
  int         sh   [3];
  logic [3:0] ma   [3];
  logic [3:0] mb   [3];

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       c;
    logic       rdy;
    logic       ov;
    logic       key;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] mx;
  } vec_t;

  vec_t tbl [18];

  always #5 clk = ~clk;

  mux_operand_loader #(.WIDTH(4), .HOLD_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .op_a(opa[0]), .op_b(opb[0]), .key(key[0]), .out_valid(ov[0]));

  mux_operand_loader #(.WIDTH(4), .HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .op_a(opa[1]), .op_b(opb[1]), .key(key[1]), .out_valid(ov[1]));

  mux_operand_loader #(.WIDTH(4), .HOLD_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[2]), .op_a(opa[2]), .op_b(opb[2]), .key(key[2]), .out_valid(ov[2]));

  // Downstream 2:1 mux fed by the HOLD_CYCLES=4 loader.
  assign mux_out4 = key[0] ? opb[0] : opa[0];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      ph[k] = 0; sh[k] = 0; ma[k] = 4'h0; mb[k] = 4'h0;
    end
  endtask

  // One rising edge: phase 0 waits for A, 1 waits for B, 2 is the window.
  task automatic model_step(input logic v, input logic [3:0] d, input logic c);
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        ph[k] = 0; sh[k] = 0;
      end else if (ph[k] == 0) begin
        if (v) begin ma[k] = d; ph[k] = 1; end
      end else if (ph[k] == 1) begin
        if (v) begin mb[k] = d; ph[k] = 2; sh[k] = 0; end
      end else begin
        sh[k] = sh[k] + 1;
        if (sh[k] == hold[k]) begin ph[k] = 0; sh[k] = 0; end
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rdy%0d", k), int'(rdy[k]), int'(ph[k] < 2));
      chk($sformatf("ov%0d", k), int'(ov[k]), int'(ph[k] == 2));
      chk($sformatf("key%0d", k), int'(key[k]), (ph[k] == 2) ? (sh[k] % 2) : 0);
      chk($sformatf("opa%0d", k), int'(opa[k]), int'(ma[k]));
      chk($sformatf("opb%0d", k), int'(opb[k]), int'(mb[k]));
    end
  endtask

  // Called at a falling edge: drive, take the rising edge, check at the next falling edge.
  task automatic drive_step(input logic v, input logic [3:0] d, input logic c);
    in_valid = v; in_data = d; clear = c;
    @(posedge clk);
    model_step(v, d, c);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      if (hold[k] < 1 || hold[k] > 255) begin
        $display("FAIL hold_param actual=%0d required=1..255", hold[k]);
        $fatal(1, "illegal HOLD_CYCLES");
      end
    end

    //          v  d     c  rdy ov key a     b     mux
    tbl[0]  = '{1, 4'hA, 0, 1,  0, 0,  4'hA, 4'h0, 4'hA};
    tbl[1]  = '{1, 4'h5, 0, 0,  1, 0,  4'hA, 4'h5, 4'hA};
    tbl[2]  = '{1, 4'h3, 0, 0,  1, 1,  4'hA, 4'h5, 4'h5};
    tbl[3]  = '{1, 4'h3, 0, 0,  1, 0,  4'hA, 4'h5, 4'hA};
    tbl[4]  = '{1, 4'h3, 0, 0,  1, 1,  4'hA, 4'h5, 4'h5};
    tbl[5]  = '{1, 4'h3, 0, 1,  0, 0,  4'hA, 4'h5, 4'hA};
    tbl[6]  = '{1, 4'h3, 0, 1,  0, 0,  4'h3, 4'h5, 4'h3};
    tbl[7]  = '{0, 4'h0, 0, 1,  0, 0,  4'h3, 4'h5, 4'h3};
    tbl[8]  = '{1, 4'h7, 1, 1,  0, 0,  4'h3, 4'h5, 4'h3};
    tbl[9]  = '{1, 4'hF, 0, 1,  0, 0,  4'hF, 4'h5, 4'hF};
    tbl[10] = '{0, 4'h0, 0, 1,  0, 0,  4'hF, 4'h5, 4'hF};
    tbl[11] = '{0, 4'h0, 0, 1,  0, 0,  4'hF, 4'h5, 4'hF};
    tbl[12] = '{0, 4'h0, 0, 1,  0, 0,  4'hF, 4'h5, 4'hF};
    tbl[13] = '{1, 4'h0, 0, 0,  1, 0,  4'hF, 4'h0, 4'hF};
    tbl[14] = '{0, 4'h0, 0, 0,  1, 1,  4'hF, 4'h0, 4'h0};
    tbl[15] = '{0, 4'h0, 0, 0,  1, 0,  4'hF, 4'h0, 4'hF};
    tbl[16] = '{0, 4'h0, 0, 0,  1, 1,  4'hF, 4'h0, 4'h0};
    tbl[17] = '{0, 4'h0, 0, 1,  0, 0,  4'hF, 4'h0, 4'hF};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model();
    rst_n = 1'b1;
    @(negedge clk);
    check_model();

    // Basic pair, backpressure, clear with same-edge transfer, gapped pair.
    for (int i = 0; i < 18; i++) begin
      drive_step(tbl[i].v, tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d_rdy", i), int'(rdy[0]), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_ov", i), int'(ov[0]), int'(tbl[i].ov));
      chk($sformatf("tbl%0d_key", i), int'(key[0]), int'(tbl[i].key));
      chk($sformatf("tbl%0d_opa", i), int'(opa[0]), int'(tbl[i].a));
      chk($sformatf("tbl%0d_opb", i), int'(opb[0]), int'(tbl[i].b));
      chk($sformatf("tbl%0d_mux", i), int'(mux_out4), int'(tbl[i].mx));
    end

    // Async reset in the second presented cycle of the HOLD_CYCLES=4 build.
    drive_step(1'b1, 4'h9, 1'b0);
    drive_step(1'b1, 4'h6, 1'b0);
    drive_step(1'b0, 4'h0, 1'b0);
    chk("pre_rst_ov", int'(ov[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ov", int'(ov[0]), 0);
    chk("rst_key", int'(key[0]), 0);
    chk("rst_opa", int'(opa[0]), 0);
    chk("rst_opb", int'(opb[0]), 0);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    drive_step(1'b1, 4'h1, 1'b0);
    drive_step(1'b1, 4'h2, 1'b0);
    chk("post_rst_opa", int'(opa[0]), 1);
    chk("post_rst_opb", int'(opb[0]), 2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post_rst_ov%0d", i), int'(ov[0]), 1);
      chk($sformatf("post_rst_mux%0d", i), int'(mux_out4), (i % 2 == 0) ? 1 : 2);
      drive_step(1'b0, 4'h0, 1'b0);
    end
    chk("post_rst_done", int'(ov[0]), 0);

    // Random stream with occasional clear.
    for (int i = 0; i < 400; i++) begin
      drive_step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_operand_loader.md
Name: mux_operand_loader

Overview:
Upstream feeder for the 4-bit 2:1 multiplexer stage (mux_1x4).
- Accepts a stream of nibbles over a valid/ready handshake and captures two consecutive nibbles as operand A and operand B.
- Presents both operands in parallel, plus a select key that alternates every cycle for a fixed window, so the downstream mux outputs A, B, A, B...
- Then re-arms for the next pair.

Parameters:
WIDTH, 4, operand width; drives the mux in1/in2 width.
HOLD_CYCLES, 4, number of cycles operands are presented (legal range 1..255).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort; return to LOAD_A
in_data  input  WIDTH  incoming nibble
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader can accept in_data this cycle
op_a  output  WIDTH  captured operand A (to mux in1)
op_b  output  WIDTH  captured operand B (to mux in2)
key  output  1  mux select (0 = op_a, 1 = op_b)
out_valid  output  1  op_a/op_b/key are a valid presentation

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values while rst_n = 0: state = LOAD_A, op_a = 0, op_b = 0, key = 0, out_valid = 0, hold counter = 0.
- in_ready is decoded from state only. It is 1 in LOAD_A and LOAD_B, and 0 in PRESENT. It has no combinational path from in_valid.
- Transfer: in_valid & in_ready at a rising edge.
- States:
  - LOAD_A: on transfer, op_a <= in_data and go to LOAD_B. Otherwise hold.
  - LOAD_B: on transfer, op_b <= in_data and go to PRESENT. Set key <= 0 and counter <= 0.
  - PRESENT: out_valid = 1. Each edge toggles key and increments the counter. When counter = HOLD_CYCLES-1, go to LOAD_A, key <= 0, and out_valid drops.
- Latency: with B accepted at edge t, out_valid rises after edge t and stays high for exactly HOLD_CYCLES cycles.
- Key sequence during PRESENT: 0,1,0,1,... For odd HOLD_CYCLES the last presented cycle has key = 0.
- op_a and op_b hold their values outside PRESENT. op_a changes only on an A transfer; op_b changes only on a B transfer.
- out_valid is a registered state decode (state == PRESENT). It is glitch-free.
- clear:
  - Has priority over everything else, including a simultaneous transfer (no capture on that edge).
  - Forces LOAD_A, key = 0, counter = 0.
  - Leaves op_a and op_b unchanged.
- in_valid during PRESENT is ignored (in_ready = 0). Upstream holds its data.
- Asynchronous reset mid-PRESENT or mid-LOAD: immediate return to reset values. A partial pair is discarded.
- Counter width is 8 bits. HOLD_CYCLES = 0 is illegal; the bench flags it with a simulation-time error.

Decomposition:
- Shared header mux_loader_defs.v, include-guarded, holds:
  - state encodings LOAD_A = 2'd0, LOAD_B = 2'd1, PRESENT = 2'd2 (2'd3 unreachable; recovers to LOAD_A);
  - default WIDTH and HOLD_CYCLES.
- One natural sub-module, hold_counter: an 8-bit counter with synchronous start/clear, async rst_n, and a terminal-count flag at HOLD_CYCLES-1.
- A top-level bench instantiates mux_operand_loader feeding mux_1x4 directly.

Test Plan:
- Reset then basic pair, HOLD_CYCLES=4: send 4'hA then 4'h5 back-to-back. Expect op_a=A and op_b=5; out_valid high for 4 cycles; key 0,1,0,1; mux out A,5,A,5; then in_ready=1.
- Backpressure: hold in_valid=1 with 4'h3 during PRESENT. Expect no capture and op_a unchanged until LOAD_A is re-entered. The first capture after the window is 4'h3.
- Gapped input: A=4'hF, then in_valid low for 3 cycles, then B=4'h0. Expect out_valid to rise only after B is accepted, with op_a=F and op_b=0.
- Clear with simultaneous transfer: in LOAD_B, assert clear with in_valid and data 4'h7. Expect state LOAD_A, op_b not 7, out_valid=0.
- Async reset mid-PRESENT (cycle 2 of 4): expect all outputs zero immediately. After release, a new pair 4'h1/4'h2 presents normally.
- HOLD_CYCLES=1 and HOLD_CYCLES=3 builds: expect out_valid width of 1 and 3 cycles respectively, with key ending at 0.
